// File: rtl/vector_abs_pipe_if.sv
// Streaming handshake bundle for vector_abs_pipe: sample in, magnitude out.
// The source/sink side uses master and the estimator uses slave.
interface vector_abs_pipe_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] x_i;
  logic [WIDTH-1:0] y_i;
  logic [1:0]       mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH:0]   abs_o;
  logic             busy_o;

  modport master (
    output valid_i, x_i, y_i, mode_i, ready_i,
    input  ready_o, valid_o, abs_o, busy_o
  );

  modport slave (
    input  valid_i, x_i, y_i, mode_i, ready_i,
    output ready_o, valid_o, abs_o, busy_o
  );
endinterface

// File: rtl/vector_abs_pipe.sv
// Three-stage 2-D magnitude estimator |(x,y)| ~= max + k*min with a global-stall
// valid/ready pipeline: S1 absolute values, S2 max/min sort, S3 weighted sum.
module vector_abs_pipe #(
  parameter int WIDTH     = 32,
  parameter int SIGNED_IN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  vector_abs_pipe_if.slave  bus
);

  // Two's-complement negation maps -2^(W-1) onto the unsigned value 2^(W-1), so no wrap.
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
    if ((SIGNED_IN != 0) && v[WIDTH-1]) begin
      f_mag = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      f_mag = v;
    end
  endfunction

  // Mode 2 floors the full 3*mn product, not the sum of separately shifted parts.
  function automatic logic [WIDTH-1:0] f_term(input logic [WIDTH-1:0] mn, input logic [1:0] mode);
    case (mode)
      2'd0:    f_term = mn >> 1;
      2'd1:    f_term = mn >> 2;
      2'd2:    f_term = WIDTH'((({2'b00, mn}) + ({2'b00, mn} << 1)) >> 3);
      2'd3:    f_term = mn;
      default: f_term = mn;
    endcase
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_ax;
  logic [WIDTH-1:0] w_ay;
  logic [WIDTH-1:0] w_mx;
  logic [WIDTH-1:0] w_mn;
  logic [WIDTH:0]   w_sum;

  logic             r_s1_v;
  logic             r_s2_v;
  logic             r_s3_v;
  logic [WIDTH-1:0] r_ax;
  logic [WIDTH-1:0] r_ay;
  logic [1:0]       r_m1;
  logic [WIDTH-1:0] r_mx;
  logic [WIDTH-1:0] r_mn;
  logic [1:0]       r_m2;
  logic [WIDTH:0]   r_abs;

  // Whole pipe shifts together (bubbles included) unless the output is blocked.
  assign w_adv = ~r_s3_v | bus.ready_i;

  // Combinational datapath for each stage boundary.
  always_comb begin
    w_ax = f_mag(bus.x_i);
    w_ay = f_mag(bus.y_i);
    if (r_ax >= r_ay) begin
      w_mx = r_ax;
      w_mn = r_ay;
    end else begin
      w_mx = r_ay;
      w_mn = r_ax;
    end
    // max + term never exceeds 2*(2^W-1), so WIDTH+1 bits hold it exactly.
    w_sum = {1'b0, r_mx} + {1'b0, f_term(r_mn, r_m2)};
  end

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
      r_s3_v <= 1'b0;
    end else if (w_adv) begin
      r_s1_v <= bus.valid_i;
      r_s2_v <= r_s1_v;
      r_s3_v <= r_s2_v;
    end else begin
      r_s1_v <= r_s1_v;
      r_s2_v <= r_s2_v;
      r_s3_v <= r_s3_v;
    end
  end

  // Stage data registers; they hold whenever the pipe is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ax  <= {WIDTH{1'b0}};
      r_ay  <= {WIDTH{1'b0}};
      r_m1  <= 2'd0;
      r_mx  <= {WIDTH{1'b0}};
      r_mn  <= {WIDTH{1'b0}};
      r_m2  <= 2'd0;
      r_abs <= {(WIDTH+1){1'b0}};
    end else if (w_adv) begin
      r_ax  <= w_ax;
      r_ay  <= w_ay;
      r_m1  <= bus.mode_i;
      r_mx  <= w_mx;
      r_mn  <= w_mn;
      r_m2  <= r_m1;
      r_abs <= w_sum;
    end else begin
      r_ax  <= r_ax;
      r_ay  <= r_ay;
      r_m1  <= r_m1;
      r_mx  <= r_mx;
      r_mn  <= r_mn;
      r_m2  <= r_m2;
      r_abs <= r_abs;
    end
  end

  assign bus.ready_o = w_adv;
  assign bus.valid_o = r_s3_v;
  assign bus.abs_o   = r_abs;
  assign bus.busy_o  = r_s1_v | r_s2_v | r_s3_v;

endmodule

// File: tb/tb_vector_abs_pipe.sv
// Directed and random self-checking bench for vector_abs_pipe (WIDTH=8, signed inputs).
module tb_vector_abs_pipe;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  vector_abs_pipe_if #(.WIDTH(W)) bus();

  vector_abs_pipe #(.WIDTH(W), .SIGNED_IN(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic int model(logic [7:0] x, logic [7:0] y, logic [1:0] m);
    int ax, ay, mx, mn, t;
    ax = $signed(x);
    ay = $signed(y);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    mx = (ax > ay) ? ax : ay;
    mn = (ax > ay) ? ay : ax;
    case (m)
      2'd0:    t = mn / 2;
      2'd1:    t = mn / 4;
      2'd2:    t = (3 * mn) / 8;
      default: t = mn;
    endcase
    return mx + t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] x, logic [7:0] y, logic [1:0] m);
    bus.valid_i = v;
    bus.x_i     = x;
    bus.y_i     = y;
    bus.mode_i  = m;
  endtask

  task automatic test_reset;
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    bus.ready_i = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    total_cnt++;
    if (bus.valid_o !== 1'b0) $display("FAIL reset_valid_o got %0b want 0", bus.valid_o); else pass_cnt++;
    total_cnt++;
    if (bus.busy_o !== 1'b0) $display("FAIL reset_busy_o got %0b want 0", bus.busy_o); else pass_cnt++;
    total_cnt++;
    if (bus.abs_o !== 9'd0) $display("FAIL reset_abs_o got %0d want 0", bus.abs_o); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.ready_o !== 1'b1) $display("FAIL reset_ready_o got %0b want 1", bus.ready_o); else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [7:0] xs [6] = '{8'd3, 8'd0, 8'd1, 8'hFD, 8'h80, 8'h80};
    logic [7:0] ys [6] = '{8'd4, 8'd0, 8'd1, 8'd4,  8'd0,  8'h80};
    logic [1:0] ms [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [8:0] ex [6] = '{9'd5, 9'd0, 9'd1, 9'd5, 9'd128, 9'd256};
    logic want_v;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) drive(1'b1, xs[c], ys[c], ms[c]);
      else drive(1'b0, 8'd0, 8'd0, 2'd0);
      #1;
      want_v = (c >= 3) && (c < 9);
      total_cnt++;
      if (bus.valid_o !== want_v) $display("FAIL directed_valid c=%0d got %0b want %0b", c, bus.valid_o, want_v); else pass_cnt++;
      if (want_v) begin
        total_cnt++;
        if (bus.abs_o !== ex[c-3]) $display("FAIL directed_abs idx=%0d got %0d want %0d", c-3, bus.abs_o, ex[c-3]); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] ex [4] = '{9'd120, 9'd110, 9'd115, 9'd140};
    logic want_v;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1'b1, 8'd100, 8'd40, 2'(c));
      else drive(1'b0, 8'd0, 8'd0, 2'd0);
      #1;
      want_v = (c >= 3) && (c < 7);
      total_cnt++;
      if (bus.valid_o !== want_v) $display("FAIL b2b_valid c=%0d got %0b want %0b", c, bus.valid_o, want_v); else pass_cnt++;
      if (want_v) begin
        total_cnt++;
        if (bus.abs_o !== ex[c-3]) $display("FAIL b2b_abs mode=%0d got %0d want %0d", c-3, bus.abs_o, ex[c-3]); else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] xs [5] = '{8'd10, 8'd0,  8'd7, 8'd50, 8'd60};
    logic [7:0] ys [5] = '{8'd0,  8'd20, 8'd7, 8'd1,  8'd2};
    logic [1:0] ms [5] = '{2'd3,  2'd3,  2'd1, 2'd0,  2'd0};
    logic [8:0] ex [3] = '{9'd10, 9'd20, 9'd8};
    int   k = 0;
    logic want_rdy;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, xs[k], ys[k], ms[k]);
      #1;
      want_rdy = (c < 3);
      total_cnt++;
      if (bus.ready_o !== want_rdy) $display("FAIL bp_ready_o c=%0d got %0b want %0b", c, bus.ready_o, want_rdy); else pass_cnt++;
      if (c >= 3) begin
        total_cnt++;
        if (bus.valid_o !== 1'b1 || bus.abs_o !== 9'd10)
          $display("FAIL bp_frozen c=%0d got v=%0b abs=%0d want v=1 abs=10", c, bus.valid_o, bus.abs_o);
        else pass_cnt++;
      end
      tick();
      if (want_rdy) k++;
    end
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    bus.ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++;
      if (bus.valid_o !== (c < 3)) $display("FAIL bp_drain_valid c=%0d got %0b want %0b", c, bus.valid_o, (c < 3)); else pass_cnt++;
      if (c < 3) begin
        total_cnt++;
        if (bus.abs_o !== ex[c]) $display("FAIL bp_drain_abs idx=%0d got %0d want %0d", c, bus.abs_o, ex[c]); else pass_cnt++;
      end
      tick();
    end
    total_cnt++;
    if (bus.busy_o !== 1'b0) $display("FAIL bp_busy_end got %0b want 0", bus.busy_o); else pass_cnt++;
  endtask

  task automatic test_reset_midstream;
    bus.ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'd5, 8'd5, 2'd3);
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    total_cnt++;
    if (bus.valid_o !== 1'b1 || bus.busy_o !== 1'b1)
      $display("FAIL rstmid_full got v=%0b busy=%0b want v=1 busy=1", bus.valid_o, bus.busy_o);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0)
      $display("FAIL rstmid_async got v=%0b busy=%0b want v=0 busy=0", bus.valid_o, bus.busy_o);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    bus.ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if (bus.valid_o !== 1'b0) $display("FAIL rstmid_stale c=%0d got %0b want 0", c, bus.valid_o); else pass_cnt++;
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, 8'hFD, 8'hFC, 2'd1);
      else drive(1'b0, 8'd0, 8'd0, 2'd0);
      #1;
      if (c == 3) begin
        total_cnt++;
        if (bus.valid_o !== 1'b1 || bus.abs_o !== 9'd4)
          $display("FAIL rstmid_after got v=%0b abs=%0d want v=1 abs=4", bus.valid_o, bus.abs_o);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_random;
    int         exp_q[$];
    int         sent = 0;
    int         e;
    logic       have = 1'b0;
    logic       hold_prev = 1'b0;
    logic [8:0] prev_abs = 9'd0;
    logic [7:0] sx = 8'd0, sy = 8'd0;
    logic [1:0] sm = 2'd0;
    for (int cyc = 0; cyc < 6000 && sent < 1000; cyc++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        sx = 8'($urandom);
        sy = 8'($urandom);
        sm = 2'($urandom);
        have = 1'b1;
      end
      drive(have, sx, sy, sm);
      bus.ready_i = ($urandom_range(0, 9) < 7);
      #1;
      total_cnt++;
      if (bus.ready_o !== (~bus.valid_o | bus.ready_i))
        $display("FAIL rand_ready_o cyc=%0d got %0b want %0b", cyc, bus.ready_o, ~bus.valid_o | bus.ready_i);
      else pass_cnt++;
      if (hold_prev) begin
        total_cnt++;
        if (bus.valid_o !== 1'b1 || bus.abs_o !== prev_abs)
          $display("FAIL rand_stable cyc=%0d got v=%0b abs=%0d want v=1 abs=%0d", cyc, bus.valid_o, bus.abs_o, prev_abs);
        else pass_cnt++;
      end
      if (bus.valid_o === 1'b1 && bus.ready_i) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_extra cyc=%0d got abs=%0d want no output", cyc, bus.abs_o);
        end else begin
          e = exp_q.pop_front();
          if ({23'd0, bus.abs_o} !== e) $display("FAIL rand_abs cyc=%0d got %0d want %0d", cyc, bus.abs_o, e);
          else pass_cnt++;
        end
      end
      if (have && bus.ready_o === 1'b1) begin
        exp_q.push_back(model(sx, sy, sm));
        have = 1'b0;
        sent++;
      end
      hold_prev = (bus.valid_o === 1'b1) && !bus.ready_i;
      prev_abs  = bus.abs_o;
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 2'd0);
    bus.ready_i = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      if (bus.valid_o === 1'b1) begin
        total_cnt++;
        e = exp_q.pop_front();
        if ({23'd0, bus.abs_o} !== e) $display("FAIL rand_drain_abs got %0d want %0d", bus.abs_o, e);
        else pass_cnt++;
      end
      tick();
    end
    #1;
    total_cnt++;
    if (sent != 1000 || exp_q.size() != 0 || bus.busy_o !== 1'b0)
      $display("FAIL rand_complete got sent=%0d left=%0d busy=%0b want sent=1000 left=0 busy=0", sent, exp_q.size(), bus.busy_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
